// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the serial boot loader and its byte receiver.
package uart_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_CSUM  = 3'd3,
        ST_STORE = 3'd4,
        ST_GO    = 3'd5
    } loader_state_t;

    localparam logic [7:0] LOADER_CMD_WRITE       = 8'h57;
    localparam logic [7:0] LOADER_CMD_GO          = 8'h47;
    localparam int         DEFAULT_CLKS_PER_BIT   = 868;
    localparam int         DEFAULT_TIMEOUT_CYCLES = 1000000;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser, mid-bit sampling, start-glitch rejection,
// one-cycle byte_valid on a good stop bit and stop_err on a bad one.
module uart_rx_byte
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       stop_err
);

    localparam int             CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  HALF = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic [1:0]    r_state;
    logic          r_rx_meta;
    logic          r_rx_sync;
    logic          r_rx_prev;
    logic [CW-1:0] r_clk_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_byte_valid;
    logic          r_stop_err;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= RX_IDLE;
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_clk_cnt    <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_stop_err   <= 1'b0;
        end else begin
            r_rx_meta    <= rx;
            r_rx_sync    <= r_rx_meta;
            r_rx_prev    <= r_rx_sync;
            r_byte_valid <= 1'b0;
            r_stop_err   <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (r_rx_prev && !r_rx_sync) begin
                        r_state   <= RX_START;
                        r_clk_cnt <= '0;
                    end
                end
                RX_START: begin
                    // A start bit that is high again at mid-bit was only a glitch.
                    if (r_clk_cnt == HALF) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        r_state   <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (r_clk_cnt == LAST) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {r_rx_sync, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= RX_STOP;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
                default: begin
                    if (r_clk_cnt == LAST) begin
                        r_clk_cnt    <= '0;
                        r_state      <= RX_IDLE;
                        r_byte_valid <= r_rx_sync;
                        r_stop_err   <= !r_rx_sync;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    assign byte_valid = r_byte_valid;
    assign byte_data  = r_shift;
    assign stop_err   = r_stop_err;

endmodule

// File: rtl/uart_loader.sv
// Serial boot loader: turns 'W' frames into bus word stores and a 'G' frame into a cpu release.
// Define UART_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte on every frame.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT   = DEFAULT_CLKS_PER_BIT,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    output logic        memory_valid,
    output logic        memory_instr,
    output logic [31:0] memory_addr,
    output logic [31:0] memory_wdata,
    output logic [3:0]  memory_wstrb,
    input  logic [31:0] memory_rdata,
    input  logic        memory_ready,
    output logic        cpu_hold,
    output logic [31:0] boot_addr,
    output logic        frame_err
);

    localparam int            TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          w_byte_valid;
    logic [7:0]    w_byte_data;
    logic          w_stop_err;
    logic          w_in_frame;
    logic          w_timeout;
    logic [31:0]   w_addr_next;
    logic [31:0]   w_data_next;
    logic          w_unused_rdata;

    loader_state_t r_state;
    logic          r_write;
    logic [1:0]    r_cnt;
    logic [31:0]   r_addr;
    logic [31:0]   r_data;
    logic [TW-1:0] r_timer;
    logic          r_mem_valid;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_wdata;
    logic [3:0]    r_mem_wstrb;
    logic          r_cpu_hold;
    logic [31:0]   r_boot_addr;
    logic          r_frame_err;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .byte_valid (w_byte_valid),
        .byte_data  (w_byte_data),
        .stop_err   (w_stop_err)
    );

    assign w_in_frame     = (r_state == ST_ADDR) || (r_state == ST_DATA) || (r_state == ST_CSUM);
    // A byte landing in the same cycle as expiry wins over the timeout.
    assign w_timeout      = w_in_frame && !w_byte_valid && (r_timer == TIMEOUT_LAST);
    assign w_addr_next    = {w_byte_data, r_addr[31:8]};
    assign w_data_next    = {w_byte_data, r_data[31:8]};
    assign w_unused_rdata = ^memory_rdata;

`ifdef UART_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_csum <= '0;
        end else if (w_byte_valid) begin
            r_csum <= (r_state == ST_IDLE) ? w_byte_data : (r_csum ^ w_byte_data);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_write     <= 1'b0;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_timer     <= '0;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_cpu_hold  <= 1'b1;
            r_boot_addr <= '0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_stop_err) begin
                r_frame_err <= 1'b1;
            end
            if (w_in_frame && !w_byte_valid) begin
                r_timer <= r_timer + TW'(1);
            end else begin
                r_timer <= '0;
            end
            if (w_timeout) begin
                r_state     <= ST_IDLE;
                r_frame_err <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_byte_valid && (w_byte_data == LOADER_CMD_WRITE)) begin
                        r_write <= 1'b1;
                        r_state <= ST_ADDR;
                    end else if (w_byte_valid && (w_byte_data == LOADER_CMD_GO)) begin
                        r_write <= 1'b0;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (w_byte_valid) begin
                        r_addr <= w_addr_next;
                        r_cnt  <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
`ifdef UART_LOADER_CHECKSUM_EN
                            r_state <= r_write ? ST_DATA : ST_CSUM;
`else
                            r_state <= r_write ? ST_DATA : ST_GO;
`endif
                        end
                    end
                end
                ST_DATA: begin
                    if (w_byte_valid) begin
                        r_data <= w_data_next;
                        r_cnt  <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
`ifdef UART_LOADER_CHECKSUM_EN
                            r_state <= ST_CSUM;
`else
                            r_state     <= ST_STORE;
                            r_mem_valid <= 1'b1;
                            r_mem_addr  <= {r_addr[31:2], 2'b00};
                            r_mem_wdata <= w_data_next;
                            r_mem_wstrb <= 4'b1111;
`endif
                        end
                    end
                end
`ifdef UART_LOADER_CHECKSUM_EN
                ST_CSUM: begin
                    if (w_byte_valid) begin
                        if (w_byte_data != r_csum) begin
                            r_state     <= ST_IDLE;
                            r_frame_err <= 1'b1;
                        end else if (r_write) begin
                            r_state     <= ST_STORE;
                            r_mem_valid <= 1'b1;
                            r_mem_addr  <= {r_addr[31:2], 2'b00};
                            r_mem_wdata <= r_data;
                            r_mem_wstrb <= 4'b1111;
                        end else begin
                            r_state <= ST_GO;
                        end
                    end
                end
`endif
                ST_STORE: begin
                    if (memory_ready) begin
                        r_mem_valid <= 1'b0;
                        r_mem_wstrb <= '0;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_GO: begin
                    r_boot_addr <= r_addr;
                    r_cpu_hold  <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign memory_valid = r_mem_valid;
    assign memory_instr = 1'b0;
    assign memory_addr  = r_mem_addr;
    assign memory_wdata = r_mem_wdata;
    assign memory_wstrb = r_mem_wstrb;
    assign cpu_hold     = r_cpu_hold;
    assign boot_addr    = r_boot_addr;
    assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboarded bench for uart_loader: frames are serialised onto rx, expected stores are
// queued from the frame contents and a bus monitor/responder pops and compares them.
module tb_uart_loader;

    localparam int CPB = 16;
    localparam int TO  = 2000;

    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx  = 1'b1;
    logic        memory_valid;
    logic        memory_instr;
    logic [31:0] memory_addr;
    logic [31:0] memory_wdata;
    logic [3:0]  memory_wstrb;
    logic [31:0] memory_rdata = 32'h0BAD_F00D;
    logic        memory_ready = 1'b0;
    logic        cpu_hold;
    logic [31:0] boot_addr;
    logic        frame_err;

    always #5 clk = ~clk;

    uart_loader #(
        .CLKS_PER_BIT   (CPB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .memory_valid (memory_valid),
        .memory_instr (memory_instr),
        .memory_addr  (memory_addr),
        .memory_wdata (memory_wdata),
        .memory_wstrb (memory_wstrb),
        .memory_rdata (memory_rdata),
        .memory_ready (memory_ready),
        .cpu_hold     (cpu_hold),
        .boot_addr    (boot_addr),
        .frame_err    (frame_err)
    );

    req_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          lat_cfg  = 1;
    logic [31:0] exp_boot = '0;
    logic        exp_hold = 1'b1;
    logic        exp_err  = 1'b0;

    bit          mon_busy = 1'b0;
    bit          mon_done = 1'b0;
    int          mon_hold = 0;
    int          mon_lat  = 1;
    logic [31:0] cap_addr;
    logic [31:0] cap_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Bus responder and scoreboard: raise ready after mon_lat valid cycles, compare on first sight.
    always @(negedge clk) begin
        if (!rst) begin
            mon_busy     = 1'b0;
            mon_done     = 1'b0;
            memory_ready = 1'b0;
        end else if (mon_done) begin
            chk("valid_drop", {31'd0, memory_valid}, 32'd0);
            mon_done     = 1'b0;
            mon_busy     = 1'b0;
            memory_ready = 1'b0;
        end else if (memory_valid) begin
            if (!mon_busy) begin
                req_t r;
                mon_busy = 1'b1;
                mon_hold = 0;
                mon_lat  = lat_cfg;
                cap_addr = memory_addr;
                cap_data = memory_wdata;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_req: got addr=%h wdata=%h, no store expected", memory_addr, memory_wdata);
                end else begin
                    r = exp_q.pop_front();
                    chk("req_addr", memory_addr, r.addr);
                    chk("req_wdata", memory_wdata, r.data);
                    chk("req_wstrb", {28'd0, memory_wstrb}, 32'hF);
                    chk("req_instr", {31'd0, memory_instr}, 32'd0);
                    $display("store addr=%h wdata=%h latency=%0d", memory_addr, memory_wdata, mon_lat);
                end
            end else begin
                chk("hold_addr", memory_addr, cap_addr);
                chk("hold_wdata", memory_wdata, cap_data);
            end
            mon_hold++;
            if (mon_hold >= mon_lat) begin
                memory_ready = 1'b1;
                mon_done     = 1'b1;
            end
        end else if (mon_busy) begin
            n_checks++;
            n_errors++;
            $display("FAIL valid_early_drop: got valid=0 after %0d cycles, required %0d", mon_hold, mon_lat);
            mon_busy = 1'b0;
        end
    end

    task automatic uart_byte(input logic [7:0] b, input bit bad_stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = !bad_stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input byte_q_t f);
        logic [7:0] cs;
        cs = 8'h00;
        foreach (f[i]) begin
            uart_byte(f[i], 1'b0);
            cs = cs ^ f[i];
        end
`ifdef UART_LOADER_CHECKSUM_EN
        uart_byte(cs, 1'b0);
`endif
    endtask

    task automatic push_le32(inout byte_q_t f, input logic [31:0] v);
        for (int i = 0; i < 4; i++) begin
            f.push_back(v[8*i +: 8]);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || mon_busy) && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("pending_stores", exp_q.size(), 32'd0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int lat);
        byte_q_t f;
        req_t    r;
        f.push_back(8'h57);
        push_le32(f, addr);
        push_le32(f, data);
        r.addr = {addr[31:2], 2'b00};
        r.data = data;
        exp_q.push_back(r);
        lat_cfg = lat;
        send_frame(f);
        drain();
    endtask

    task automatic do_go(input logic [31:0] addr);
        byte_q_t f;
        f.push_back(8'h47);
        push_le32(f, addr);
        exp_boot = addr;
        exp_hold = 1'b0;
        send_frame(f);
        repeat (5) @(negedge clk);
        chk("boot_addr", boot_addr, exp_boot);
        chk("cpu_hold", {31'd0, cpu_hold}, {31'd0, exp_hold});
        $display("go addr=%h boot_addr=%h cpu_hold=%0d", addr, boot_addr, cpu_hold);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        exp_boot = '0;
        exp_hold = 1'b1;
        exp_err  = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        do_reset();
        repeat (100) @(negedge clk);
        chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_valid", {31'd0, memory_valid}, 32'd0);
        chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst_boot_addr", boot_addr, 32'd0);
        chk("rst_mem_addr", memory_addr, 32'd0);
        chk("rst_wstrb", {28'd0, memory_wstrb}, 32'd0);

        do_write(32'h0000_0100, 32'hDEAD_BEEF, 3);

        do_go(32'h0000_0080);
        do_write(32'h0000_2007, 32'h1234_5678, 2);
        chk("hold_after_write", {31'd0, cpu_hold}, 32'd0);

        uart_byte(8'h57, 1'b0);
        uart_byte(8'h00, 1'b0);
        uart_byte(8'h01, 1'b0);
        chk("err_before_timeout", {31'd0, frame_err}, 32'd0);
        repeat (TO + 300) @(negedge clk);
        exp_err = 1'b1;
        chk("timeout_err", {31'd0, frame_err}, 32'd1);
        $display("timeout frame_err=%0d", frame_err);
        do_write(32'h0000_0400, 32'hCAFE_F00D, 1);

        for (int n = 0; n < 15; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                logic [7:0] j;
                j = 8'($urandom);
                if (j == 8'h57 || j == 8'h47) begin
                    j = 8'h00;
                end
                uart_byte(j, 1'b0);
            end
            if ($urandom_range(0, 3) == 0) begin
                do_go($urandom);
            end else begin
                do_write($urandom, $urandom, int'($urandom_range(1, 4)));
            end
            chk("rand_frame_err", {31'd0, frame_err}, {31'd0, exp_err});
            chk("rand_cpu_hold", {31'd0, cpu_hold}, {31'd0, exp_hold});
        end

        do_reset();
        chk("rst2_frame_err", {31'd0, frame_err}, 32'd0);
        chk("rst2_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        uart_byte(8'h41, 1'b1);
        uart_byte(8'h5A, 1'b0);
        repeat (20) @(negedge clk);
        exp_err = 1'b1;
        chk("stop_err", {31'd0, frame_err}, 32'd1);
        chk("stop_no_valid", {31'd0, memory_valid}, 32'd0);
        $display("bad stop frame_err=%0d", frame_err);
        do_write(32'h0000_0804, 32'hA5A5_0F0F, 2);

`ifdef UART_LOADER_CHECKSUM_EN
        do_reset();
        uart_byte(8'h47, 1'b0);
        uart_byte(8'h80, 1'b0);
        uart_byte(8'h00, 1'b0);
        uart_byte(8'h00, 1'b0);
        uart_byte(8'h00, 1'b0);
        uart_byte(8'hC7, 1'b0);
        repeat (5) @(negedge clk);
        chk("csum_ok_boot", boot_addr, 32'h80);
        chk("csum_ok_hold", {31'd0, cpu_hold}, 32'd0);
        chk("csum_ok_err", {31'd0, frame_err}, 32'd0);
        $display("csum good boot_addr=%h cpu_hold=%0d", boot_addr, cpu_hold);

        do_reset();
        uart_byte(8'h47, 1'b0);
        uart_byte(8'h80, 1'b0);
        uart_byte(8'h00, 1'b0);
        uart_byte(8'h00, 1'b0);
        uart_byte(8'h00, 1'b0);
        uart_byte(8'h00, 1'b0);
        repeat (5) @(negedge clk);
        chk("csum_bad_hold", {31'd0, cpu_hold}, 32'd1);
        chk("csum_bad_err", {31'd0, frame_err}, 32'd1);
        chk("csum_bad_boot", boot_addr, 32'd0);
        $display("csum bad cpu_hold=%0d frame_err=%0d", cpu_hold, frame_err);
`endif

        repeat (20) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
